// File: rtl/box_overlay_pkg.sv
// Shared types and dout field layout for the box_overlay rasteriser.
// dout is packed as {mask, frame, addr, pixel data}, pixel data at the LSB end.
package box_overlay_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int PIX_BITS = 8;
  localparam int FRAME_W  = 1;

  function automatic int data_w(input int ppw);
    return PIX_BITS * ppw;
  endfunction

  function automatic int addr_lsb(input int ppw);
    return data_w(ppw);
  endfunction

  function automatic int frame_lsb(input int ppw, input int aw);
    return addr_lsb(ppw) + aw;
  endfunction

  function automatic int mask_lsb(input int ppw, input int aw);
    return frame_lsb(ppw, aw) + FRAME_W;
  endfunction

  function automatic int dout_w(input int ppw, input int aw);
    return mask_lsb(ppw, aw) + ppw;
  endfunction

endpackage

// File: rtl/box_overlay_addr.sv
// Maps a pixel coordinate to its framebuffer word address and byte-lane mask.
module box_overlay_addr
  import box_overlay_pkg::*;
#(
  parameter int FB_WIDTH     = 800,
  parameter int PIX_PER_WORD = 4,
  parameter int X_W          = 10,
  parameter int Y_W          = 10,
  parameter int ADDR_W       = 17
) (
  input  logic [X_W-1:0]          x,
  input  logic [Y_W-1:0]          y,
  output logic [ADDR_W-1:0]       addr,
  output logic [PIX_PER_WORD-1:0] mask
);

  localparam int SHIFT         = $clog2(PIX_PER_WORD);
  localparam int WORDS_PER_ROW = FB_WIDTH / PIX_PER_WORD;
  localparam logic [X_W-1:0] LANE_MASK = X_W'(PIX_PER_WORD - 1);

  assign addr = ADDR_W'(32'(x >> SHIFT) + 32'(WORDS_PER_ROW) * 32'(y));
  assign mask = PIX_PER_WORD'(1) << (x & LANE_MASK);

endmodule

// File: rtl/box_overlay.sv
// Rasterises a clipped box (outline, or solid when BOX_OVERLAY_FILL_EN is defined)
// into a stream of one-pixel framebuffer write beats with valid/ready handshake.
module box_overlay
  import box_overlay_pkg::*;
#(
  parameter int FB_WIDTH     = 800,
  parameter int FB_HEIGHT    = 600,
  parameter int PIX_PER_WORD = 4,
  parameter int X_W          = 10,
  parameter int Y_W          = 10,
  parameter int ADDR_W       = 17
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          start,
  output logic                                          start_ack,
  input  logic [X_W-1:0]                                x0,
  input  logic [Y_W-1:0]                                y0,
  input  logic [X_W-1:0]                                w,
  input  logic [Y_W-1:0]                                h,
  input  logic [7:0]                                    color,
  input  logic                                          fill,
  output logic [PIX_PER_WORD+1+ADDR_W+8*PIX_PER_WORD-1:0] dout,
  output logic                                          valid,
  input  logic                                          ready,
  output logic                                          done,
  input  logic                                          done_ack,
  output logic                                          busy
);

  localparam int DATA_W  = data_w(PIX_PER_WORD);
  localparam int ADDR_LO = addr_lsb(PIX_PER_WORD);
  localparam int FRAME_B = frame_lsb(PIX_PER_WORD, ADDR_W);
  localparam int MASK_LO = mask_lsb(PIX_PER_WORD, ADDR_W);

  localparam logic [X_W:0] FB_W_C = (X_W+1)'(FB_WIDTH);
  localparam logic [Y_W:0] FB_H_C = (Y_W+1)'(FB_HEIGHT);
  localparam logic [X_W:0] X_MAX  = (X_W+1)'(FB_WIDTH - 1);
  localparam logic [Y_W:0] Y_MAX  = (Y_W+1)'(FB_HEIGHT - 1);

  state_e            state_reg;
  logic              start_ack_reg, done_reg, frame_reg, empty_pend_reg;
  logic [X_W-1:0]    x_reg, x0_reg, x1_reg, x_next, x1_in;
  logic [Y_W-1:0]    y_reg, y0_reg, y1_reg, y_next, y1_in;
  logic [7:0]        color_reg;
  logic [X_W:0]      x_end;
  logic [Y_W:0]      y_end;
  logic              box_empty, accept, beat_fire, last_beat, done_set, row_full;
  logic [ADDR_W-1:0]       pix_addr;
  logic [PIX_PER_WORD-1:0] pix_mask;
  logic [DATA_W-1:0]       pix_data;

  // End coordinates are formed one bit wider so x0+w-1 cannot wrap before clipping.
  assign x_end     = {1'b0, x0} + {1'b0, w} - (X_W+1)'(1);
  assign y_end     = {1'b0, y0} + {1'b0, h} - (Y_W+1)'(1);
  assign x1_in     = (x_end > X_MAX) ? X_MAX[X_W-1:0] : x_end[X_W-1:0];
  assign y1_in     = (y_end > Y_MAX) ? Y_MAX[Y_W-1:0] : y_end[Y_W-1:0];
  assign box_empty = (w == '0) || (h == '0) || ({1'b0, x0} >= FB_W_C) || ({1'b0, y0} >= FB_H_C);

  // An empty draw still owes a done pulse one cycle later, so hold off new starts until then.
  assign accept    = start && (state_reg == IDLE) && !empty_pend_reg;
  assign beat_fire = (state_reg == RUN) && ready;
  assign last_beat = (x_reg == x1_reg) && (y_reg == y1_reg);
  assign done_set  = empty_pend_reg || (beat_fire && last_beat);

`ifdef BOX_OVERLAY_FILL_EN
  logic fill_reg;
  always_ff @(posedge clock) begin
    if (reset)       fill_reg <= 1'b0;
    else if (accept) fill_reg <= fill;
  end
  assign row_full = fill_reg || (y_reg == y0_reg) || (y_reg == y1_reg);
`else
  logic unused_fill;
  assign unused_fill = fill;
  assign row_full    = (y_reg == y0_reg) || (y_reg == y1_reg);
`endif

  // Interior outline rows visit only the left edge, then the right edge when distinct.
  always_comb begin
    x_next = x_reg;
    y_next = y_reg;
    if (row_full) begin
      if (x_reg != x1_reg) begin
        x_next = x_reg + X_W'(1);
      end else begin
        x_next = x0_reg;
        y_next = y_reg + Y_W'(1);
      end
    end else if ((x_reg == x0_reg) && (x1_reg != x0_reg)) begin
      x_next = x1_reg;
    end else begin
      x_next = x0_reg;
      y_next = y_reg + Y_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      start_ack_reg  <= 1'b0;
      done_reg       <= 1'b0;
      frame_reg      <= 1'b1;
      empty_pend_reg <= 1'b0;
      x_reg          <= '0;
      y_reg          <= '0;
      x0_reg         <= '0;
      y0_reg         <= '0;
      x1_reg         <= '0;
      y1_reg         <= '0;
      color_reg      <= '0;
    end else begin
      start_ack_reg  <= accept;
      empty_pend_reg <= accept && box_empty;
      if (done_set)      done_reg <= 1'b1;
      else if (done_ack) done_reg <= 1'b0;
      if (done_set)      frame_reg <= ~frame_reg;

      if (accept) begin
        x0_reg    <= x0;
        y0_reg    <= y0;
        x1_reg    <= x1_in;
        y1_reg    <= y1_in;
        color_reg <= color;
        x_reg     <= x0;
        y_reg     <= y0;
        if (!box_empty) state_reg <= RUN;
      end else if (beat_fire) begin
        if (last_beat) begin
          state_reg <= IDLE;
        end else begin
          x_reg <= x_next;
          y_reg <= y_next;
        end
      end
    end
  end

  box_overlay_addr #(
    .FB_WIDTH    (FB_WIDTH),
    .PIX_PER_WORD(PIX_PER_WORD),
    .X_W         (X_W),
    .Y_W         (Y_W),
    .ADDR_W      (ADDR_W)
  ) u_addr (
    .x   (x_reg),
    .y   (y_reg),
    .addr(pix_addr),
    .mask(pix_mask)
  );

  generate
    for (genvar gi = 0; gi < PIX_PER_WORD; gi++) begin : g_lane
      assign pix_data[gi*PIX_BITS +: PIX_BITS] = color_reg;
    end
  endgenerate

  assign dout[DATA_W-1:0]                    = pix_data;
  assign dout[ADDR_LO +: ADDR_W]             = pix_addr;
  assign dout[FRAME_B]                       = frame_reg;
  assign dout[MASK_LO +: PIX_PER_WORD]       = pix_mask;

  assign valid     = (state_reg == RUN);
  assign busy      = (state_reg != IDLE);
  assign start_ack = start_ack_reg;
  assign done      = done_reg;

endmodule
